// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Looks up the fetch PC combinationally and trains from branches resolved in the C stage.
module branch_target_predictor #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [XLEN-1:0]  PC_I,
  output logic             Predict_I,
  output logic [XLEN-1:0]  Prediction_I,
  input  logic             Update_C,
  input  logic [XLEN-1:0]  UpdPC_C,
  input  logic [XLEN-1:0]  UpdTarget_C,
  input  logic             UpdTaken_C,
  input  logic             UpdJump_C,
  input  logic             Mispredict_C,
  input  logic             FlushTable,
  output logic [CNT_W-1:0] MispredictCount
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

  logic [ENTRIES-1:0]  valid;
  logic [TAG_W-1:0]    tags    [ENTRIES];
  logic [XLEN-1:0]     targets [ENTRIES];
  logic [CTR_BITS-1:0] ctrs    [ENTRIES];

  logic [IDX-1:0]      look_idx;
  logic [TAG_W-1:0]    look_tag;
  logic                look_hit;

  logic [IDX-1:0]      upd_idx;
  logic [TAG_W-1:0]    upd_tag;
  logic                upd_hit;
  logic                upd_write;
  logic [XLEN-1:0]     new_target;
  logic [CTR_BITS-1:0] new_ctr;

  // The two byte-offset bits of a PC never select anything.
  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, PC_I[1:0], UpdPC_C[1:0]};

  assign look_idx     = PC_I[IDX+1:2];
  assign look_tag     = PC_I[XLEN-1:IDX+2];
  assign look_hit     = valid[look_idx] && (tags[look_idx] == look_tag);
  assign Predict_I    = look_hit && ctrs[look_idx][CTR_BITS-1];
  assign Prediction_I = Predict_I ? {targets[look_idx][XLEN-1:1], 1'b0} : '0;

  assign upd_idx = UpdPC_C[IDX+1:2];
  assign upd_tag = UpdPC_C[XLEN-1:IDX+2];
  assign upd_hit = valid[upd_idx] && (tags[upd_idx] == upd_tag);

  // A not-taken branch that misses leaves the table untouched rather than allocating.
  always_comb begin
    upd_write  = 1'b0;
    new_target = targets[upd_idx];
    new_ctr    = ctrs[upd_idx];
    if (Update_C) begin
      if (UpdJump_C) begin
        upd_write  = 1'b1;
        new_target = UpdTarget_C;
        new_ctr    = CTR_MAX;
      end else if (upd_hit && UpdTaken_C) begin
        upd_write  = 1'b1;
        new_target = UpdTarget_C;
        if (ctrs[upd_idx] != CTR_MAX) new_ctr = ctrs[upd_idx] + CTR_BITS'(1);
      end else if (upd_hit) begin
        upd_write = 1'b1;
        if (ctrs[upd_idx] != '0) new_ctr = ctrs[upd_idx] - CTR_BITS'(1);
      end else if (UpdTaken_C) begin
        upd_write  = 1'b1;
        new_target = UpdTarget_C;
        new_ctr    = CTR_WEAK;
      end
    end
  end

  // Flush is assigned last so it overrides a same-cycle valid set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tags[i]    <= '0;
        targets[i] <= '0;
        ctrs[i]    <= '0;
      end
    end else begin
      if (upd_write) begin
        valid[upd_idx]   <= 1'b1;
        tags[upd_idx]    <= upd_tag;
        targets[upd_idx] <= new_target;
        ctrs[upd_idx]    <= new_ctr;
      end
      if (FlushTable) valid <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      MispredictCount <= '0;
    end else if (Update_C && Mispredict_C && (MispredictCount != '1)) begin
      MispredictCount <= MispredictCount + CNT_W'(1);
    end
  end

endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Parametrised next-PC predictor for the instruction stage: a direct-mapped branch target buffer with per-entry saturating direction counters.
- Looks up the fetch PC combinationally and drives `Predict_I` / `Prediction_I` to the PC update logic.
- Trains from resolved branches and jumps reported by the C stage.
- Keeps a running mispredict count for performance monitoring.
- Generalises the prior fixed jump-only handling to configurable table depth, counter width and XLEN, with learned branch direction.

## Interface
Parameters:
- `XLEN`, 32, datapath/PC width.
- `ENTRIES`, 16, BTB entries; power of two, 2..1024. `IDX = log2(ENTRIES)`.
- `CTR_BITS`, 2, direction counter width, 1..4.
- `CNT_W`, 32, mispredict counter width.

Ports:
- `clk` input 1: clock, rising edge.
- `reset_n` input 1: asynchronous active-low reset.
- `PC_I` input XLEN: fetch PC to look up.
- `Predict_I` output 1: predict taken for `PC_I`.
- `Prediction_I` output XLEN: predicted target, bit 0 forced 0.
- `Update_C` input 1: a branch/jump resolved in C this cycle.
- `UpdPC_C` input XLEN: PC of the resolved instruction.
- `UpdTarget_C` input XLEN: resolved target.
- `UpdTaken_C` input 1: resolved taken (always 1 for jumps).
- `UpdJump_C` input 1: instruction is an unconditional jump.
- `Mispredict_C` input 1: C-stage prediction was wrong; qualified by `Update_C`.
- `FlushTable` input 1: invalidate all entries (e.g. fence.i).
- `MispredictCount` output CNT_W: saturating count of mispredicts.

## Operation
Entry contents: `valid`, `tag` (`XLEN-IDX-2` bits), `target` (XLEN), `ctr` (CTR_BITS).
- Index = `PC[IDX+1:2]`; tag = `PC[XLEN-1:IDX+2]`.

Lookup (combinational):
- hit = `valid[idx] && tag[idx] == tag(PC_I)`.
- `Predict_I` = hit && `ctr` MSB == 1.
- `Prediction_I` = `{target[XLEN-1:1], 1'b0}` when `Predict_I`, else all zeros.

Update (clocked, when `Update_C`), with `u` = index of `UpdPC_C` and hit(u) = valid && tag match:
- Jump, any state: write valid=1, tag, target=`UpdTarget_C`, ctr=all ones.
- Branch, hit, taken: ctr saturating +1; target overwritten.
- Branch, hit, not taken: ctr saturating −1; target unchanged.
- Branch, miss, taken: allocate/replace; ctr = weakly taken (MSB 1, others 0, i.e. `2'b10` for CTR_BITS=2).
- Branch, miss, not taken: no change.

Other clocked behaviour:
- `MispredictCount` += 1 when `Update_C && Mispredict_C`; saturates at all ones, no wrap.
- `FlushTable`: clears every `valid` at the next edge. Counters and targets are kept but unreachable.
- Flush and update in the same cycle: flush wins; the updated entry is left invalid.

Reset (`reset_n` low, asynchronous):
- All `valid`, `ctr` and `target` = 0; `MispredictCount` = 0.
- `Predict_I` = 0 and `Prediction_I` = 0 while in reset.
- Reset asserted mid-update discards the update.

## Timing
- Lookup has zero latency: outputs are a pure function of `PC_I` and table state.
- Update takes effect at the rising edge following `Update_C`. A same-cycle lookup of the same index sees the pre-update contents; there is no write-to-read bypass.
- `MispredictCount` reflects a mispredict one cycle after it is reported.
- Reset deassertion is synchronised externally. The first update is accepted on the first edge with `reset_n` high.
- No handshakes. `Update_C` is a single-cycle strobe per resolved instruction, and at most one update occurs per cycle.

## Test plan
1. After reset, `PC_I`=0x40 -> `Predict_I`=0, `Prediction_I`=0, `MispredictCount`=0.
2. Jump at 0x40, target 0x101 (`Update_C`=1, `UpdJump_C`=1). Next cycle `PC_I`=0x40 -> `Predict_I`=1, `Prediction_I`=0x100. Then `PC_I`=0x80 (same index, different tag) -> `Predict_I`=0.
3. Branch at 0x44: taken -> ctr=2, predict 1. Not taken -> ctr=1, predict 0. Not taken twice -> ctr=0 (saturates). Taken three times -> ctr=3 (saturates), predict 1.
4. Branch not taken at 0x48 on a miss -> entry stays invalid, `Predict_I`=0. Lookup of 0x44 in the same cycle as its update -> old value returned, new value visible next cycle.
5. Populate 3 entries, assert `FlushTable` together with a jump update at 0x50 -> all lookups `Predict_I`=0 next cycle. Then drop `reset_n` asynchronously mid-cycle -> outputs 0 immediately.
6. CNT_W=4: 20 cycles of `Update_C`=1, `Mispredict_C`=1 -> count saturates at 15. Strobes with `Update_C`=0 -> no increment.
